// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: one DIGIT-bit slice per cycle, MSB slice first, early exit.
// Define COMPARE_STATS_EN to add saturating per-result counters and the clr_stats input.
module seq_magnitude_comparator #(
    parameter int WIDTH  = 16,
    parameter int DIGIT  = 4,
    parameter int STAT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             a_greater,
    output logic             b_greater,
`ifdef COMPARE_STATS_EN
    input  logic              clr_stats,
    output logic [STAT_W-1:0] cnt_eq,
    output logic [STAT_W-1:0] cnt_agt,
    output logic [STAT_W-1:0] cnt_bgt,
`endif
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for an operand handshake
    // CMP   | comparing slice idx, walking from the top slice down
    // DONE  | result held on the outputs until out_ready

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $fatal(1, "seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sgn_q;
    logic [IDX_W-1:0]   idx;
    logic [DIGIT-1:0]   sa;
    logic [DIGIT-1:0]   sb;

    assign in_ready = (state == IDLE) & rst_n;
    assign busy     = (state != IDLE);

    // Flipping the sign bit of the top slice turns two's complement into offset binary,
    // so a plain unsigned slice compare orders signed operands correctly.
    always_comb begin
        sa = a_q[int'(idx)*DIGIT +: DIGIT];
        sb = b_q[int'(idx)*DIGIT +: DIGIT];
        if (sgn_q && (idx == TOP_IDX)) begin
            sa[DIGIT-1] = ~sa[DIGIT-1];
            sb[DIGIT-1] = ~sb[DIGIT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            equal     <= 1'b0;
            a_greater <= 1'b0;
            b_greater <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        sgn_q <= is_signed;
                        idx   <= TOP_IDX;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (sa > sb) begin
                        a_greater <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (sa < sb) begin
                        b_greater <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (idx == '0) begin
                        equal     <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        equal     <= 1'b0;
                        a_greater <= 1'b0;
                        b_greater <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COMPARE_STATS_EN
    logic out_hs;
    assign out_hs = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_eq  <= '0;
            cnt_agt <= '0;
            cnt_bgt <= '0;
        end else if (clr_stats) begin
            cnt_eq  <= '0;
            cnt_agt <= '0;
            cnt_bgt <= '0;
        end else if (out_hs) begin
            if (equal && (cnt_eq != '1))
                cnt_eq <= cnt_eq + 1'b1;
            if (a_greater && (cnt_agt != '1))
                cnt_agt <= cnt_agt + 1'b1;
            if (b_greater && (cnt_bgt != '1))
                cnt_bgt <= cnt_bgt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4) against an arithmetic model.
// Stats checks are built only when COMPARE_STATS_EN is defined.
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              is_signed = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              equal;
    logic              a_greater;
    logic              b_greater;
    logic              busy;
`ifdef COMPARE_STATS_EN
    logic              clr_stats = 1'b0;
    logic [15:0]       cnt_eq;
    logic [15:0]       cnt_agt;
    logic [15:0]       cnt_bgt;
    int                m_eq = 0;
    int                m_agt = 0;
    int                m_bgt = 0;
`endif

    int checks = 0;
    int errors = 0;
    logic clr_on_hs = 1'b0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .STAT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .equal     (equal),
        .a_greater (a_greater),
        .b_greater (b_greater),
`ifdef COMPARE_STATS_EN
        .clr_stats (clr_stats),
        .cnt_eq    (cnt_eq),
        .cnt_agt   (cnt_agt),
        .cnt_bgt   (cnt_bgt),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected result as {equal, a_greater, b_greater} from plain integer compare.
    function automatic logic [2:0] model_res(input logic [15:0] x, input logic [15:0] y, input logic s);
        int ix, iy;
        ix = s ? int'($signed(x)) : int'({16'b0, x});
        iy = s ? int'($signed(y)) : int'({16'b0, y});
        if (ix == iy) return 3'b100;
        if (ix > iy)  return 3'b010;
        return 3'b001;
    endfunction

    // Slices examined: position of the highest differing nibble counted from the top.
    function automatic int model_lat(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] d;
        d = x ^ y;
        for (int i = NDIG - 1; i >= 0; i--)
            if (((d >> (i * DIGIT)) & 16'hF) != 0) return NDIG - i;
        return NDIG;
    endfunction

    task automatic run(input logic [15:0] ta, input logic [15:0] tb_, input logic s, input int hold);
        logic [2:0] er;
        int         ek;
        int         cyc;
        er = model_res(ta, tb_, s);
        ek = model_lat(ta, tb_);
        a = ta; b = tb_; is_signed = s; in_valid = 1'b1;
        out_ready = (hold <= 1);
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < NDIG + 2) begin
            check("in_ready_cmp", in_ready, 0);
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("out_valid_timeout", out_valid, 1);
        check("latency", cyc, ek);
        check("result", {equal, a_greater, b_greater}, er);
        check("busy_done", busy, 1);
        for (int h = 1; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("held_valid", out_valid, 1);
            check("held_result", {equal, a_greater, b_greater}, er);
            check("held_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
`ifdef COMPARE_STATS_EN
        clr_stats = clr_on_hs;
        if (clr_on_hs) begin
            m_eq = 0; m_agt = 0; m_bgt = 0;
        end else begin
            m_eq  += int'(er[2]);
            m_agt += int'(er[1]);
            m_bgt += int'(er[0]);
        end
`endif
        @(posedge clk); #1;
`ifdef COMPARE_STATS_EN
        clr_stats = 1'b0;
`endif
        out_ready = 1'b0;
        check("valid_cleared", out_valid, 0);
        check("result_cleared", {equal, a_greater, b_greater}, 3'b000);
        check("in_ready_back", in_ready, 1);
        check("busy_back", busy, 0);
    endtask

    task automatic start_only(input logic [15:0] ta, input logic [15:0] tb_);
        a = ta; b = tb_; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_results", {equal, a_greater, b_greater}, 3'b000);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);
    endtask

    initial begin
        logic [15:0] ra, rb, mask;
        int          sel;
        repeat (3) @(posedge clk);
        #1;
        check("por_in_ready", in_ready, 0);
        check("por_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("por_rel_in_ready", in_ready, 1);
        check("por_busy", busy, 0);

        // equal: full NDIG latency
        run(16'h1234, 16'h1234, 1'b0, 1);
        // top slice decides; signedness flips the answer
        run(16'h8000, 16'h7FFF, 1'b0, 1);
        run(16'h8000, 16'h7FFF, 1'b1, 1);
        // bottom slice decides, result held while out_ready low
        run(16'h00A5, 16'h00A6, 1'b0, 3);
        run(16'hFFFF, 16'h0000, 1'b1, 2);
        run(16'h8000, 16'h8000, 1'b1, 1);

        // reset while result is pending in DONE
        start_only(16'h0001, 16'h0001);
        repeat (NDIG) @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        reset_pulse();

        // reset during CMP: no result may appear
        start_only(16'hFFFF, 16'hFFFE);
        @(posedge clk); #1;
        reset_pulse();
        for (int i = 0; i < NDIG + 2; i++) begin
            @(posedge clk); #1;
            check("no_stale_valid", out_valid, 0);
        end
        run(16'h0001, 16'h0002, 1'b0, 1);

        for (int n = 0; n < 40; n++) begin
            ra   = 16'($urandom);
            sel  = $urandom_range(0, 4);
            mask = (sel == 0) ? 16'h0 : 16'($urandom & ((1 << (4 * sel)) - 1));
            rb   = ra ^ mask;
            run(ra, rb, 1'($urandom), $urandom_range(1, 3));
        end

`ifdef COMPARE_STATS_EN
        reset_pulse();
        m_eq = 0; m_agt = 0; m_bgt = 0;
        run(16'h0005, 16'h0003, 1'b0, 1);
        run(16'h7000, 16'h1000, 1'b1, 2);
        run(16'h4444, 16'h4444, 1'b0, 1);
        check("cnt_agt", cnt_agt, 32'(m_agt));
        check("cnt_eq", cnt_eq, 32'(m_eq));
        check("cnt_bgt", cnt_bgt, 32'(m_bgt));
        check("cnt_agt_abs", cnt_agt, 2);
        clr_on_hs = 1'b1;
        run(16'h0001, 16'h0009, 1'b0, 1);
        clr_on_hs = 1'b0;
        check("clr_eq", cnt_eq, 0);
        check("clr_agt", cnt_agt, 0);
        check("clr_bgt", cnt_bgt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
